// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset release sequencer: FSM states,
// legal parameter ranges and a small constant helper.
package reset_seq_pkg;

    localparam int unsigned DEPTH_MIN    = 2;
    localparam int unsigned DEPTH_MAX    = 8;
    localparam int unsigned CHANNELS_MIN = 1;
    localparam int unsigned CHANNELS_MAX = 16;
    localparam int unsigned STRETCH_MIN  = 1;
    localparam int unsigned STRETCH_MAX  = 255;
    localparam int unsigned STAGGER_MIN  = 1;
    localparam int unsigned STAGGER_MAX  = 255;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sync_shiftreg.sv
// Reset-deassertion synchronizer: a DEPTH-stage shift register fed with
// constant 1 and cleared asynchronously by the raw reset.
// q[1] is the synchronized output, q[0] the stage feeding it, so the
// consumer can act on the same edge the output first becomes 1.
module reset_sync_shiftreg #(
    parameter int unsigned DEPTH = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [1:0] q
);

    logic [DEPTH-1:0] stages;

    // Shift a 1 in from stage 0; every stage clears while reset_n is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], 1'b1};
        end
    end

    assign q = stages[DEPTH-1 -: 2];

endmodule

// File: rtl/reset_seq_sync.sv
// Reset release sequencer: synchronizes raw reset deassertion, holds all
// channels in reset for STRETCH cycles, then releases channel 0..N-1 with
// STAGGER cycles between them. A software request re-runs the release
// sequence without re-running the synchronizer.
module reset_seq_sync
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned STRETCH  = 4,
    parameter int unsigned STAGGER  = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                sw_reset_req,
    output logic [CHANNELS-1:0] rst_n_o,
    output logic                seq_done
);

    localparam int unsigned CNT_W = $clog2(max_u(STRETCH, STAGGER) + 1);
    localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(CHANNELS - 1);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX ||
        CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
        STRETCH < STRETCH_MIN || STRETCH > STRETCH_MAX ||
        STAGGER < STAGGER_MIN || STAGGER > STAGGER_MAX) begin : g_bad_params
        $error("reset_seq_sync: parameter out of legal range");
    end

    logic [1:0]       sync_q;
    seq_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    reset_sync_shiftreg #(
        .DEPTH (DEPTH)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .q       (sync_q)
    );

    // Sequencing FSM; outputs are registered here so nothing combinational
    // reaches rst_n_o or seq_done. Leaving SYNC keys off the stage before the
    // synchronizer output, so the move happens on the edge the output rises.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_SYNC;
            cnt      <= '0;
            idx      <= '0;
            rst_n_o  <= '0;
            seq_done <= 1'b0;
        end else if (sw_reset_req && state != ST_SYNC) begin
            state    <= ST_STRETCH;
            cnt      <= STRETCH_LOAD;
            idx      <= '0;
            rst_n_o  <= '0;
            seq_done <= 1'b0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (sync_q[0] && !sync_q[1]) begin
                        state <= ST_STRETCH;
                        cnt   <= STRETCH_LOAD;
                    end
                end
                ST_STRETCH: begin
                    if (cnt == '0) begin
                        rst_n_o[0] <= 1'b1;
                        cnt        <= STAGGER_LOAD;
                        if (CHANNELS == 1) begin
                            state    <= ST_DONE;
                            seq_done <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                            idx   <= IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt == '0) begin
                        rst_n_o[idx] <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state    <= ST_DONE;
                            seq_done <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            cnt <= STAGGER_LOAD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq_sync.sv
// Bench for reset_seq_sync: two instances (default configuration and a
// single-channel, STRETCH=1 configuration) share clock and inputs.
// Expectations come from spec timing constants in the directed tasks and
// from a release-time model in the randomized task.
module tb_reset_seq_sync;

    localparam int unsigned DEPTH_TB = 3;

    logic       clock;
    logic       reset_n;
    logic       sw_reset_req;
    logic [1:0] rst_a;
    logic       done_a;
    logic [0:0] rst_b;
    logic       done_b;

    int checks = 0;
    int errors = 0;

    reset_seq_sync #(
        .DEPTH    (3),
        .CHANNELS (2),
        .STRETCH  (4),
        .STAGGER  (2)
    ) dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .sw_reset_req (sw_reset_req),
        .rst_n_o      (rst_a),
        .seq_done     (done_a)
    );

    reset_seq_sync #(
        .DEPTH    (3),
        .CHANNELS (1),
        .STRETCH  (1),
        .STAGGER  (2)
    ) dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .sw_reset_req (sw_reset_req),
        .rst_n_o      (rst_b),
        .seq_done     (done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the edge at which the current release sequence began.
    // Channel k releases STRETCH + k*STAGGER edges after that start edge.
    int unsigned m_edges;
    bit          m_started;
    int unsigned m_start;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_edges   <= 0;
            m_started <= 1'b0;
            m_start   <= 0;
        end else begin
            m_edges <= m_edges + 1;
            if (!m_started) begin
                if (m_edges + 1 == DEPTH_TB) begin
                    m_started <= 1'b1;
                    m_start   <= m_edges + 1;
                end
            end else if (sw_reset_req) begin
                m_start <= m_edges + 1;
            end
        end
    end

    function automatic logic [16:0] model_out(input int unsigned ch,
                                              input int unsigned stretch,
                                              input int unsigned stagger);
        logic [16:0] v;
        bit          all_rel;
        v       = '0;
        all_rel = 1'b1;
        for (int unsigned k = 0; k < ch; k++) begin
            if (m_started && m_edges >= m_start + stretch + k * stagger) v[k] = 1'b1;
            else all_rel = 1'b0;
        end
        v[ch] = all_rel;
        return v;
    endfunction

    task automatic wait_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b1;
        sw_reset_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({done_a, rst_a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_a: got %b want 000", {done_a, rst_a});
        end
        checks++;
        if ({done_b, rst_b} !== 2'b00) begin
            errors++;
            $display("FAIL reset_async_b: got %b want 00", {done_b, rst_b});
        end
        sw_reset_req = 1'b1;
        repeat (3) begin
            wait_edge();
            checks++;
            if ({done_a, rst_a} !== 3'b000 || {done_b, rst_b} !== 2'b00) begin
                errors++;
                $display("FAIL reset_held: got a=%b b=%b want a=000 b=00", {done_a, rst_a}, {done_b, rst_b});
            end
        end
        sw_reset_req = 1'b0;
    endtask

    task automatic test_power_on();
        logic [2:0] ea;
        logic [1:0] eb;
        reset_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            wait_edge();
            ea = {e >= 9, e >= 9, e >= 7};
            eb = {e >= 4, e >= 4};
            checks++;
            if ({done_a, rst_a} !== ea) begin
                errors++;
                $display("FAIL power_on_a edge %0d: got %b want %b", e, {done_a, rst_a}, ea);
            end
            checks++;
            if ({done_b, rst_b} !== eb) begin
                errors++;
                $display("FAIL power_on_b edge %0d: got %b want %b", e, {done_b, rst_b}, eb);
            end
        end
    endtask

    task automatic test_async_assert();
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({done_a, rst_a} !== 3'b000 || {done_b, rst_b} !== 2'b00) begin
            errors++;
            $display("FAIL async_assert: got a=%b b=%b want a=000 b=00", {done_a, rst_a}, {done_b, rst_b});
        end
        repeat (2) begin
            wait_edge();
            checks++;
            if ({done_a, rst_a} !== 3'b000 || {done_b, rst_b} !== 2'b00) begin
                errors++;
                $display("FAIL async_hold: got a=%b b=%b want a=000 b=00", {done_a, rst_a}, {done_b, rst_b});
            end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] ea;
        logic [1:0] eb;
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            wait_edge();
            if (e == 2) reset_n = 1'b0;
            checks++;
            if ({done_a, rst_a} !== 3'b000 || {done_b, rst_b} !== 2'b00) begin
                errors++;
                $display("FAIL glitch edge %0d: got a=%b b=%b want a=000 b=00", e, {done_a, rst_a}, {done_b, rst_b});
            end
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            wait_edge();
            ea = {e >= 9, e >= 9, e >= 7};
            eb = {e >= 4, e >= 4};
            checks++;
            if ({done_a, rst_a} !== ea || {done_b, rst_b} !== eb) begin
                errors++;
                $display("FAIL glitch_resequence edge %0d: got a=%b b=%b want a=%b b=%b",
                         e, {done_a, rst_a}, {done_b, rst_b}, ea, eb);
            end
        end
    endtask

    task automatic restart_check(input int hold, input string name);
        logic [2:0] ea;
        logic [1:0] eb;
        sw_reset_req = 1'b1;
        for (int h = 0; h < hold; h++) begin
            wait_edge();
            if (h == hold - 1) sw_reset_req = 1'b0;
            checks++;
            if ({done_a, rst_a} !== 3'b000 || {done_b, rst_b} !== 2'b00) begin
                errors++;
                $display("FAIL %s_low: got a=%b b=%b want a=000 b=00", name, {done_a, rst_a}, {done_b, rst_b});
            end
        end
        for (int j = 1; j <= 7; j++) begin
            wait_edge();
            ea = {j >= 6, j >= 6, j >= 4};
            eb = {j >= 1, j >= 1};
            checks++;
            if ({done_a, rst_a} !== ea || {done_b, rst_b} !== eb) begin
                errors++;
                $display("FAIL %s N+%0d: got a=%b b=%b want a=%b b=%b",
                         name, j, {done_a, rst_a}, {done_b, rst_b}, ea, eb);
            end
        end
    endtask

    task automatic test_sw_restart_done();
        restart_check(1, "sw_restart_done");
    endtask

    task automatic test_held_request();
        restart_check(3, "held_request");
    endtask

    task automatic test_mid_restart();
        logic [2:0] ea;
        logic [1:0] eb;
        reset_n = 1'b0;
        wait_edge();
        reset_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            wait_edge();
            ea[0] = (e == 7) || (e >= 12);
            ea[1] = (e >= 14);
            ea[2] = (e >= 14);
            eb    = (e < 8) ? {e >= 4, e >= 4} : {e >= 9, e >= 9};
            checks++;
            if ({done_a, rst_a} !== ea || {done_b, rst_b} !== eb) begin
                errors++;
                $display("FAIL mid_restart edge %0d: got a=%b b=%b want a=%b b=%b",
                         e, {done_a, rst_a}, {done_b, rst_b}, ea, eb);
            end
            if (e == 7) sw_reset_req = 1'b1;
            if (e == 8) sw_reset_req = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [16:0] ma;
        logic [16:0] mb;
        for (int i = 0; i < 3000; i++) begin
            wait_edge();
            ma = model_out(2, 4, 2);
            mb = model_out(1, 1, 2);
            checks++;
            if ({done_a, rst_a} !== ma[2:0] || {done_b, rst_b} !== mb[1:0]) begin
                errors++;
                $display("FAIL random cycle %0d: got a=%b b=%b want a=%b b=%b",
                         i, {done_a, rst_a}, {done_b, rst_b}, ma[2:0], mb[1:0]);
            end
            if (!reset_n) begin
                if ($urandom_range(0, 99) < 30) reset_n = 1'b1;
            end else if ($urandom_range(0, 199) < 3) begin
                #2 reset_n = 1'b0;
                #1;
                ma = model_out(2, 4, 2);
                mb = model_out(1, 1, 2);
                checks++;
                if ({done_a, rst_a} !== ma[2:0] || {done_b, rst_b} !== mb[1:0]) begin
                    errors++;
                    $display("FAIL random_async cycle %0d: got a=%b b=%b want a=%b b=%b",
                             i, {done_a, rst_a}, {done_b, rst_b}, ma[2:0], mb[1:0]);
                end
            end
            sw_reset_req = ($urandom_range(0, 99) < (sw_reset_req ? 60 : 6));
        end
        sw_reset_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_async_assert();
        test_glitch();
        test_sw_restart_done();
        test_held_request();
        test_mid_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
